pipe_mem_arbiter: RTL

PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

---
 rtl/cpu_types_pkg.sv | 30 +++
 rtl/arb_timer.sv | 44 ++++
 rtl/pipe_mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared types for the pipeline memory arbiter: the machine word,
//               the RAM status code and the arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/arb_timer.sv
// ============================================================================
// Module      : arb_timer
// Description : Clearable, saturating up-counter that measures how long a
//               grant has been waiting for the RAM. o_expired is high once the
//               count has reached MAX_WAIT.
// Ports       : clk       - clock
//               rst       - synchronous active-high reset
//               i_clr     - clear count to 0 (priority over i_inc)
//               i_inc     - count one waiting cycle
//               o_expired - count == MAX_WAIT
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_timer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max  = (r_cnt == CNT_W'(MAX_WAIT));
  assign o_expired = w_at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_mem_arbiter.sv
// ============================================================================
// Module      : pipe_mem_arbiter
// Description : Arbitrates a single-port RAM between an instruction fetch
//               requester and a data requester. Data normally wins, but after
//               FAIR_LIMIT consecutive data accesses with a fetch pending the
//               fetch is served. A grant that waits MAX_WAIT cycles, or sees
//               ERROR, is abandoned and flagged in the sticky arb_err.
// Ports       : CLK, RST                      - clock, sync active-high reset
//               iREN/iaddr/iload/iwait        - instruction requester
//               dREN/dWEN/daddr/dstore/dload/dwait - data requester
//               ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate - RAM side
//               arb_err                       - sticky timeout/ERROR flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int FAIR_LIMIT = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      arb_err
);

  localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [FAIR_W-1:0] r_fair_cnt;
  logic              r_err;

  logic w_dreq, w_access, w_ig, w_dg;
  logic w_timeout, w_fail;
  logic w_i_done, w_d_done, w_set_err;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == ACCESS);
  assign w_ig     = (r_state == IGRANT);
  assign w_dg     = (r_state == DGRANT);
  assign w_fail   = w_timeout || (ramstate == ERROR);

  // Leaving IDLE is the only way into a grant, so clearing while idle gives
  // every grant a fresh count.
  arb_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk       (CLK),
    .rst       (RST),
    .i_clr     (r_state == IDLE),
    .i_inc     ((w_ig | w_dg) & ~w_access),
    .o_expired (w_timeout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A dropped request is checked first: it leaves quietly. ACCESS is checked
  // before the failure causes so that a completion on the timeout cycle wins.
  always_comb begin
    w_next    = r_state;
    w_i_done  = 1'b0;
    w_d_done  = 1'b0;
    w_set_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dreq && (r_fair_cnt < FAIR_W'(FAIR_LIMIT))) w_next = DGRANT;
        else if (iREN)                                    w_next = IGRANT;
        else if (w_dreq)                                  w_next = DGRANT;
      end
      IGRANT: begin
        if (!iREN) begin
          w_next = IDLE;
        end else if (w_access) begin
          w_next   = IDLE;
          w_i_done = 1'b1;
        end else if (w_fail) begin
          w_next    = IDLE;
          w_set_err = 1'b1;
        end
      end
      DGRANT: begin
        if (!w_dreq) begin
          w_next = IDLE;
        end else if (w_access) begin
          w_next   = IDLE;
          w_d_done = 1'b1;
        end else if (w_fail) begin
          w_next    = IDLE;
          w_set_err = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Counts consecutive data completions only while a fetch is actually waiting.
  always_ff @(posedge CLK) begin
    if (RST || !iREN || w_i_done) begin
      r_fair_cnt <= '0;
    end else if (w_d_done && (r_fair_cnt < FAIR_W'(FAIR_LIMIT))) begin
      r_fair_cnt <= r_fair_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_set_err) begin
      r_err <= 1'b1;
    end
  end

  assign arb_err = r_err;

  // RAM side: everything is zero outside the grant states; a write wins over a
  // read when the data side asserts both.
  assign ramREN   = w_ig | (w_dg & dREN & ~dWEN);
  assign ramWEN   = w_dg & dWEN;
  assign ramaddr  = w_ig ? iaddr : (w_dg ? daddr : '0);
  assign ramstore = w_dg ? dstore : '0;

  assign iwait = iREN   & ~(w_ig & w_access);
  assign dwait = w_dreq & ~(w_dg & w_access);
  assign iload = (w_ig & w_access) ? ramload : '0;
  assign dload = (w_dg & w_access) ? ramload : '0;

endmodule

`default_nettype wire
